// File: rtl/clk_ctrl.sv
// CPU clock/reset controller: waits for PLL lock, holds CPU reset, then
// issues clock enables in free-run, divided slow-run or debounced single-step.
module clk_ctrl #(
   parameter int unsigned RST_CYCLES = 16,
   parameter int unsigned DEB_CYCLES = 1024,
   parameter int unsigned DIV_W      = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pll_lock,
   input  logic             run_req,
   input  logic             step_btn,
   input  logic             slow_mode,
   input  logic [DIV_W-1:0] div_val,
   output logic             cpu_rst_n,
   output logic             cpu_en,
   output logic [2:0]       state_o,
   output logic [15:0]      en_cnt
);

   localparam int unsigned HOLD_W = $clog2(RST_CYCLES + 1);
   localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      RST_HOLD  = 3'd1,
      STOP      = 3'd2,
      RUN       = 3'd3,
      STEP      = 3'd4
   } state_t;

   state_t             state, state_nx;
   logic [1:0]         lock_q, run_q, btn_q;
   logic               lock_s, run_s, btn_s;
   logic [DEB_W-1:0]   deb_cnt;
   logic               deb_lvl, deb_prev;
   logic               step_c;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [DIV_W-1:0]   div_cnt;
   logic               div_match_c;
   logic               cpu_rst_nx, cpu_en_nx;

   assign lock_s      = lock_q[1];
   assign run_s       = run_q[1];
   assign btn_s       = btn_q[1];
   assign step_c      = deb_lvl & ~deb_prev;
   assign div_match_c = (div_cnt >= div_val);
   assign state_o     = state;

   // Two-flop synchronizers for the asynchronous inputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q <= '0;
         run_q  <= '0;
         btn_q  <= '0;
      end else begin
         lock_q <= {lock_q[0], pll_lock};
         run_q  <= {run_q[0], run_req};
         btn_q  <= {btn_q[0], step_btn};
      end
   end

   // Debounce: accept a new button level only after DEB_CYCLES steady differing cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_cnt  <= '0;
         deb_lvl  <= 1'b0;
         deb_prev <= 1'b0;
      end else begin
         deb_prev <= deb_lvl;
         if (btn_s == deb_lvl) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            deb_lvl <= btn_s;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
         end
      end
   end

   // Reset-hold and slow-mode divider counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= '0;
         div_cnt  <= '0;
      end else begin
         hold_cnt <= (state == RST_HOLD) ? hold_cnt + HOLD_W'(1) : '0;
         if (state != RUN || div_match_c) div_cnt <= '0;
         else                             div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // State register and registered CPU controls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= WAIT_LOCK;
         cpu_rst_n <= 1'b0;
         cpu_en    <= 1'b0;
      end else begin
         state     <= state_nx;
         cpu_rst_n <= cpu_rst_nx;
         cpu_en    <= cpu_en_nx;
      end
   end

   // Next-state and next-output logic; loss of lock overrides everything
   always_comb begin
      state_nx   = state;
      cpu_rst_nx = 1'b1;
      cpu_en_nx  = 1'b0;
      case (state)
         WAIT_LOCK: begin
            cpu_rst_nx = 1'b0;
            if (lock_s) state_nx = RST_HOLD;
         end
         RST_HOLD: begin
            cpu_rst_nx = 1'b0;
            if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) state_nx = STOP;
         end
         STOP: begin
            if (run_s)       state_nx = RUN;
            else if (step_c) state_nx = STEP;
         end
         RUN: begin
            cpu_en_nx = ~slow_mode | div_match_c;
            if (!run_s) state_nx = STOP;
         end
         STEP: begin
            cpu_en_nx = 1'b1;
            state_nx  = STOP;
         end
         default: state_nx = WAIT_LOCK;
      endcase
      if (state != WAIT_LOCK && !lock_s) state_nx = WAIT_LOCK;
   end

   // Enable counter, cleared while the CPU is held in reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          en_cnt <= '0;
      else if (!cpu_rst_n) en_cnt <= '0;
      else if (cpu_en)     en_cnt <= en_cnt + 16'd1;
   end

endmodule

// File: tb/tb_clk_ctrl.sv
// Bench for clk_ctrl: directed scenarios, a cycle model compared every cycle,
// and literal timing checks that pin the model.
module tb_clk_ctrl;

   localparam int RST_C = 4;
   localparam int DEB_C = 8;
   localparam int S_WAIT = 0, S_HOLD = 1, S_STOP = 2, S_RUN = 3, S_STEP = 4;

   logic       clk = 1'b0;
   logic       rst_n, pll_lock, run_req, step_btn, slow_mode;
   logic [7:0] div_val;
   logic       cpu_rst_n, cpu_en;
   logic [2:0] state_o;
   logic [15:0] en_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   clk_ctrl #(.RST_CYCLES(4), .DEB_CYCLES(8), .DIV_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .run_req(run_req),
      .step_btn(step_btn), .slow_mode(slow_mode), .div_val(div_val),
      .cpu_rst_n(cpu_rst_n), .cpu_en(cpu_en), .state_o(state_o), .en_cnt(en_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         if (n_bad < 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- behavioural model ----------------
   int m_l1, m_ls, m_r1, m_rs, m_b1, m_bs;
   int m_lvl, m_lvl_d, m_diff;
   int m_st, m_hold, m_since;
   int m_rstn, m_en, m_cnt;

   task automatic model_reset();
      m_l1 = 0; m_ls = 0; m_r1 = 0; m_rs = 0; m_b1 = 0; m_bs = 0;
      m_lvl = 0; m_lvl_d = 0; m_diff = 0;
      m_st = S_WAIT; m_hold = 0; m_since = 0;
      m_rstn = 0; m_en = 0; m_cnt = 0;
   endtask

   task automatic model_step();
      int step_now, hit, nst, n_rstn, n_en, n_cnt;
      step_now = (m_lvl == 1 && m_lvl_d == 0) ? 1 : 0;
      hit      = (m_since >= int'(div_val)) ? 1 : 0;
      n_cnt    = (m_rstn == 0) ? 0 : (m_cnt + m_en) % 65536;
      n_rstn   = (m_st >= S_STOP) ? 1 : 0;
      n_en     = (m_st == S_STEP || (m_st == S_RUN && (slow_mode == 1'b0 || hit == 1))) ? 1 : 0;
      if (m_st != S_WAIT && m_ls == 0) nst = S_WAIT;
      else begin
         case (m_st)
            S_WAIT:  nst = m_ls ? S_HOLD : S_WAIT;
            S_HOLD:  nst = (m_hold + 1 >= RST_C) ? S_STOP : S_HOLD;
            S_STOP:  nst = m_rs ? S_RUN : (step_now ? S_STEP : S_STOP);
            S_RUN:   nst = m_rs ? S_RUN : S_STOP;
            default: nst = S_STOP;
         endcase
      end
      m_hold  = (m_st == S_HOLD) ? m_hold + 1 : 0;
      m_since = (m_st == S_RUN && hit == 0) ? m_since + 1 : 0;
      m_lvl_d = m_lvl;
      if (m_bs != m_lvl) begin
         m_diff++;
         if (m_diff == DEB_C) begin
            m_lvl  = m_bs;
            m_diff = 0;
         end
      end else m_diff = 0;
      m_ls = m_l1; m_l1 = int'(pll_lock);
      m_rs = m_r1; m_r1 = int'(run_req);
      m_bs = m_b1; m_b1 = int'(step_btn);
      m_st = nst; m_rstn = n_rstn; m_en = n_en; m_cnt = n_cnt;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (rst_n !== 1'b1) model_reset();
         else model_step();
      end
   end

   // Every-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            check("state_o", int'(state_o), m_st);
            check("cpu_rst_n", int'(cpu_rst_n), m_rstn);
            check("cpu_en", int'(cpu_en), m_en);
            check("en_cnt", int'(en_cnt), m_cnt);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int highs, streak, best, pulses, last, gap_bad, found;
      int step_seen, step_at, en_pulses, en_at;

      rst_n = 1'b0; pll_lock = 1'b0; run_req = 1'b0; step_btn = 1'b0;
      slow_mode = 1'b0; div_val = 8'd0;
      tick(3);
      check("rst_state", int'(state_o), 0);
      check("rst_cpu_rst_n", int'(cpu_rst_n), 0);
      check("rst_cpu_en", int'(cpu_en), 0);
      check("rst_en_cnt", int'(en_cnt), 0);
      rst_n = 1'b1;
      tick(2);

      // lock -> RST_HOLD after 3 cycles, STOP after 4 hold cycles
      pll_lock = 1'b1;
      tick(2); check("lock_wait_state", int'(state_o), 0);
      tick(1); check("lock_hold_state", int'(state_o), 1);
      tick(3); check("hold_last_state", int'(state_o), 1);
      tick(1); check("stop_state", int'(state_o), 2);
      check("stop_entry_rst", int'(cpu_rst_n), 0);
      tick(1); check("cpu_rst_rise", int'(cpu_rst_n), 1);

      // free run for 20 cycles
      highs = 0; streak = 0; best = 0;
      run_req = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (i == 20) run_req = 1'b0;
         tick(1);
         if (cpu_en) begin highs++; streak++; if (streak > best) best = streak; end
         else streak = 0;
      end
      check("run_highs", highs, 20);
      check("run_streak", best, 20);
      check("run_en_cnt", int'(en_cnt), 20);
      check("run_back_stop", int'(state_o), 2);

      // slow mode, div_val=3, 16 RUN cycles
      slow_mode = 1'b1; div_val = 8'd3; run_req = 1'b1;
      pulses = 0; last = -1; gap_bad = 0;
      for (int i = 0; i < 40; i++) begin
         if (i == 16) run_req = 1'b0;
         tick(1);
         if (cpu_en) begin
            if (last >= 0 && i - last != 4) gap_bad++;
            last = i; pulses++;
         end
      end
      check("slow_pulses", pulses, 4);
      check("slow_gap_bad", gap_bad, 0);
      check("slow_en_cnt", int'(en_cnt), 24);

      // divide value shortened mid-count
      run_req = 1'b1; found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         tick(1);
         if (cpu_en) found = 1;
      end
      check("slow_pulse_found", found, 1);
      tick(2);
      check("div_mid_quiet", int'(cpu_en), 0);
      div_val = 8'd1;
      tick(1);
      check("div_change_pulse", int'(cpu_en), 1);
      run_req = 1'b0;
      tick(8);
      slow_mode = 1'b0; div_val = 8'd0;

      // bouncing step button, then held
      step_btn = 1'b1; tick(1); step_btn = 1'b0; tick(1);
      step_btn = 1'b1; tick(1); step_btn = 1'b0; tick(1);
      step_btn = 1'b1;
      step_seen = 0; step_at = -1; en_pulses = 0; en_at = -1;
      for (int i = 1; i <= 40; i++) begin
         tick(1);
         if (state_o == 3'd4) begin step_seen++; step_at = i; end
         if (cpu_en) begin en_pulses++; en_at = i; end
      end
      check("step_visits", step_seen, 1);
      check("step_latency", step_at, 11);
      check("step_en_pulses", en_pulses, 1);
      check("step_en_latency", en_at, 12);
      step_btn = 1'b0;
      tick(15);

      // run request and step pulse land in the same STOP cycle
      step_btn = 1'b1; step_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (i == 8) run_req = 1'b1;
         tick(1);
         if (state_o == 3'd4) step_seen++;
         if (i == 10) check("tie_run_entry", int'(state_o), 3);
      end
      check("tie_no_step", step_seen, 0);
      check("tie_in_run", int'(state_o), 3);
      run_req = 1'b0; step_btn = 1'b0;
      tick(15);

      // lock loss during RUN, then relock
      run_req = 1'b1;
      tick(10);
      check("pre_drop_en", int'(cpu_en), 1);
      pll_lock = 1'b0; run_req = 1'b0;
      tick(3); check("drop_state", int'(state_o), 0);
      tick(2);
      check("drop_cpu_en", int'(cpu_en), 0);
      check("drop_cpu_rst_n", int'(cpu_rst_n), 0);
      check("drop_en_cnt", int'(en_cnt), 0);
      pll_lock = 1'b1;
      tick(3); check("relock_hold", int'(state_o), 1);
      tick(4); check("relock_stop", int'(state_o), 2);
      check("relock_rst_low", int'(cpu_rst_n), 0);
      tick(1); check("relock_rst_rise", int'(cpu_rst_n), 1);

      // asynchronous reset mid-RUN
      run_req = 1'b1;
      tick(8);
      check("pre_rst_en", int'(cpu_en), 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_cpu_en", int'(cpu_en), 0);
      check("arst_state", int'(state_o), 0);
      check("arst_cpu_rst_n", int'(cpu_rst_n), 0);
      check("arst_en_cnt", int'(en_cnt), 0);
      tick(2);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check("post_rst_no_en", int'(cpu_en), 0);
      end
      tick(20);
      run_req = 1'b0;
      tick(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/clk_ctrl.md
CLK_CTRL -- requirements
Module: clk_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 16: cycles cpu_rst_n is held low after PLL lock is seen.
REQ-002 Parameter DEB_CYCLES, default 1024: stable cycles required to accept a new step_btn level.
REQ-003 Parameter DIV_W, default 24: width of div_val and of the slow-mode divider counter.
REQ-004 clk  in  1  system clock, the PLL output clock of the clock generator.
REQ-005 rst_n  in  1  asynchronous active-low reset for the whole block.
REQ-006 pll_lock  in  1  PLL lock indicator, asynchronous to clk.
REQ-007 run_req  in  1  level: 1 = free-run CPU, 0 = stop; asynchronous.
REQ-008 step_btn  in  1  raw, bouncing single-step push button; asynchronous.
REQ-009 slow_mode  in  1  1 = RUN issues divided enable pulses; quasi-static.
REQ-010 div_val  in  DIV_W  slow-mode divide value: one pulse every div_val+1 cycles.
REQ-011 cpu_rst_n  out  1  registered active-low CPU reset.
REQ-012 cpu_en  out  1  registered CPU clock enable; the CPU advances one step per high cycle.
REQ-013 state_o  out  3  current state encoding.
REQ-014 en_cnt  out  16  count of cpu_en high cycles since cpu_rst_n last rose.

Function
REQ-015 pll_lock, run_req and step_btn SHALL each pass through a 2-flop synchronizer before use (lock_s, run_s, btn_s).
REQ-016 Debounce: debounced level SHALL change only after btn_s differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-017 A one-cycle step pulse SHALL occur on each 0->1 transition of the debounced level; a held button SHALL give exactly one pulse.
REQ-018 States: WAIT_LOCK=0, RST_HOLD=1, STOP=2, RUN=3, STEP=4; codes 5-7 SHALL go to WAIT_LOCK.
REQ-019 WAIT_LOCK: lock_s=1 SHALL go to RST_HOLD with the hold counter cleared.
REQ-020 RST_HOLD: after RST_CYCLES cycles in this state SHALL go to STOP.
REQ-021 In every state except WAIT_LOCK, lock_s=0 SHALL go to WAIT_LOCK next cycle; this overrides all other transitions.
REQ-022 STOP: run_s=1 SHALL go to RUN; else a step pulse SHALL go to STEP; run_s wins if both occur.
REQ-023 RUN: run_s=0 SHALL go to STOP; step pulses in RUN SHALL be discarded.
REQ-024 STEP SHALL last exactly one cycle, then go to STOP regardless of run_s.
REQ-025 cpu_rst_n SHALL be 0 in the cycle after any cycle in WAIT_LOCK or RST_HOLD, and 1 otherwise.
REQ-026 cpu_en SHALL be 1 in the cycle after: a STEP-state cycle; or a RUN cycle with slow_mode=0; or a RUN cycle with slow_mode=1 and divider match. Otherwise it SHALL be 0.
REQ-027 Divider: 0 on RUN entry; divider match occurs when count >= div_val, and the count then clears to 0; otherwise it increments. div_val=0 SHALL equal full speed.
REQ-028 en_cnt SHALL increment on each cpu_en=1 cycle, wrap 0xFFFF->0, and be held at 0 while cpu_rst_n=0.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state WAIT_LOCK, cpu_rst_n=0, cpu_en=0, en_cnt=0, and all synchronizers and counters to 0, with a debounced level of 0.
REQ-030 rst_n assertion mid-RUN or mid-STEP SHALL drop cpu_en immediately, with no extra pulse after release.

Verification (RST_CYCLES=4, DEB_CYCLES=8, DIV_W=8)
REQ-031 Raise pll_lock after reset -> state_o 0->1 three cycles later; STOP after 4 RST_HOLD cycles; cpu_rst_n rises 1 cycle after STOP entry.
REQ-032 STOP, run_req=1, slow_mode=0 for 20 cycles, then 0 -> 20 consecutive cpu_en highs; en_cnt=20; state back to STOP.
REQ-033 RUN, slow_mode=1, div_val=3 for 16 cycles -> cpu_en pulses every 4th cycle, 4 pulses total; switching div_val 3->1 mid-count -> next pulse on the following cycle.
REQ-034 STOP, step_btn bounces 5 times within 6 cycles, then held 40 cycles -> exactly one STEP state and one cpu_en pulse, ~DEB_CYCLES+3 cycles after settling.
REQ-035 Drop pll_lock during RUN -> WAIT_LOCK within 3 cycles; cpu_en=0 and cpu_rst_n=0; en_cnt=0; relock repeats the RST_HOLD sequence.
REQ-036 run_req rising and step pulse in the same STOP cycle -> RUN entered; STEP never visited.
